sprite_line_scheduler: RTL
==========================

// Module: sprite_line_scheduler
// PURPOSE
//  Per-scanline sprite prefetch sequencer. Starts on a line_start pulse and scans the sprite attribute table.
//  For each sprite that intersects next_line, it reads that sprite's row from the selected sprite ROM.
//  Non-transparent pixels go into the prefetch line buffer through its write port.
//  The display side reads the other buffer and clears it to 0 after reading each pixel.
// PARAMETERS
//  NUM_SPRITES  4    number of attribute slots; slot 0 has highest priority
//  HACTIVE      640  visible pixels per line; lb_addr range 0..HACTIVE-1
//  ADDR_W       10   ROM address width (max sprite 32x32 = 1024 words)
// PORTS
//  clk          in   1                 system clock
//  reset        in   1                 asynchronous, active-high reset
//  line_start   in   1                 1-cycle pulse: begin preparing next_line
//  next_line    in   10                scanline to prepare; sampled on line_start
//  sprite_attr  in   NUM_SPRITES*32    packed slots {dim[31:25],id[24:20],y[19:10],x[9:0]}; slot i at [32i+31:32i]
//  rom_sel      out  5                 ROM id being read (1 ship, 2 pig, 3 bee; 0 none)
//  rom_addr     out  ADDR_W            ROM word address; data returns next cycle
//  rom_data     in   24                RGB888 pixel from the selected ROM, 1-cycle latency
//  lb_we        out  1                 line-buffer write strobe
//  lb_addr      out  10                line-buffer pixel column
//  lb_data      out  24                line-buffer pixel
//  busy         out  1                 high in every state except IDLE
//  done         out  1                 1-cycle pulse when the line is complete
//  overrun      out  1                 1-cycle pulse when line_start arrives while busy
// BEHAVIOUR
//  - Reset: FSM goes to IDLE; every output is 0 immediately (asynchronous); pipeline valid bit is cleared.
//  - Snapshot: on line_start, latch next_line and all of sprite_attr; later changes to sprite_attr do not affect the line in progress.
//  - FSM IDLE: on line_start -> SCAN with slot = NUM_SPRITES-1.
//  - FSM SCAN: 1 cycle per slot.
//    - Hit when all hold: attr != 0; id in 1..3; dim != 0; y <= line <= y+dim-1.
//    - The range compare is 11-bit unsigned, so y+dim is never allowed to wrap.
//    - Hit -> FETCH with col = 0.
//    - Miss -> next lower slot, or -> DONE after slot 0.
//  - FSM FETCH: one ROM read per cycle, col = 0..dim-1.
//    - rom_addr = (line-y)*dim + col, truncated to ADDR_W.
//    - rom_sel = id for the whole FETCH.
//    - After col = dim-1 -> DRAIN.
//  - FSM DRAIN: 1 cycle to write the last returned pixel, then SCAN the next lower slot, or DONE after slot 0.
//  - FSM DONE: done = 1 for one cycle -> IDLE.
//  - Write pipeline: the cycle after each read, lb_we = 1 only if BOTH hold:
//    - rom_data != 0 (0 is transparent);
//    - x + col_d < HACTIVE (x+col computed in 11 bits).
//    Then lb_addr = x + col_d and lb_data = rom_data.
//  - Clipped or transparent pixels are still read from the ROM; they are just not written.
//  - Priority: slots are processed from high index to low. Lower slots are written later and overwrite higher ones where they overlap.
//  - Latency: DONE is reached 1 + NUM_SPRITES + sum over hit slots of (dim+1) cycles after line_start.
//  - line_start while busy:
//    - overrun pulses for 1 cycle;
//    - the current line is abandoned and the in-flight write is suppressed;
//    - the FSM restarts SCAN from the top slot with the new snapshot;
//    - done is not pulsed for the abandoned line.
//  - rom_sel and rom_addr are 0 outside FETCH. lb_we is 0 in IDLE and SCAN, except for the pipelined write in the first cycle after FETCH.
// STRUCTURE
//  - Shared package sprite_pkg:
//    - sprite_attr_t packed struct {dim, id, y, x};
//    - ID_NONE=0, ID_SHIP=1, ID_PIG=2, ID_BEE=3;
//    - HACTIVE, VACTIVE constants;
//    - FSM state enum.
//  - One sub-module, sprite_hit_check: combinational; inputs sprite_attr_t and line; outputs hit and row = line-y.
// TESTING
//  1. slot0 = {dim 32, id 1, y 50, x 100}, other slots 0; line_start with next_line 50
//     -> rom_sel 1 and rom_addr 0..31 on cycles 5..36;
//     -> lb writes at lb_addr 100..131 on cycles 6..37;
//     -> done on cycle 38; busy covers cycles 1..38.
//  2. Same sprite, next_line 81 -> rom_addr 992..1023. Same sprite, next_line 82 -> no lb_we, done on cycle 5.
//  3. slot0 x 620, dim 32 -> 32 ROM reads; lb writes at lb_addr 620..639 only.
//  4. slot0 {id 2, x 100}, slot1 {id 3, x 110}, both dim 32 and both hit
//     -> slot1 is fetched first, then slot0;
//     -> final contents at lb_addr 110..131 are pig ROM data.
//  5. rom_data forced to 0 for odd addresses -> lb_we low for odd columns; even columns are written.
//  6. line_start during FETCH -> overrun pulse, no done for the old line, new scan completes normally.
//     Reset asserted mid-FETCH -> lb_we, busy and rom_sel go to 0 immediately.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite attribute layout, ROM ids, display constants and scheduler states.
package sprite_pkg;

    localparam int HACTIVE = 640;
    localparam int VACTIVE = 480;

    localparam logic [4:0] ID_NONE = 5'd0;
    localparam logic [4:0] ID_SHIP = 5'd1;
    localparam logic [4:0] ID_PIG  = 5'd2;
    localparam logic [4:0] ID_BEE  = 5'd3;

    typedef struct packed {
        logic [6:0] dim;
        logic [4:0] id;
        logic [9:0] y;
        logic [9:0] x;
    } sprite_attr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/sprite_hit_check.sv
// sprite_hit_check: decides whether a sprite covers a scanline and which sprite row that is.
module sprite_hit_check
    import sprite_pkg::*;
(
    input  sprite_attr_t attr,
    input  logic [9:0]   line,
    output logic         hit,
    output logic [9:0]   row
);
    logic [10:0] bottom;

    // 11-bit sum so a sprite near the last line never wraps back to the top
    assign bottom = {1'b0, attr.y} + 11'(attr.dim);
    assign hit = attr != '0 && attr.id >= ID_SHIP && attr.id <= ID_BEE && attr.dim != '0
                 && line >= attr.y && {1'b0, line} < bottom;
    assign row = line - attr.y;

endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: scans a snapshot of the sprite table each line and streams visible sprite rows
// from the sprite ROMs into the prefetch line buffer.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES = 4,
    parameter int HACTIVE     = 640,
    parameter int ADDR_W      = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     line_start,
    input  logic [9:0]               next_line,
    input  logic [NUM_SPRITES*32-1:0] sprite_attr,
    output logic [4:0]               rom_sel,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [23:0]              rom_data,
    output logic                     lb_we,
    output logic [9:0]               lb_addr,
    output logic [23:0]              lb_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);
    import sprite_pkg::*;

    localparam int SW = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;

    state_t        state, state_n;
    logic [SW-1:0] slot, slot_n;
    logic [6:0]    col, col_n, col_d;
    logic [9:0]    line;
    sprite_attr_t  attr [NUM_SPRITES];
    sprite_attr_t  cur;
    logic          hit, pend;
    logic [9:0]    row;
    logic [10:0]   wcol;

    assign cur = attr[slot];

    sprite_hit_check u_hit (
        .attr(cur),
        .line(line),
        .hit (hit),
        .row (row)
    );

    always_comb begin
        state_n = state;
        slot_n  = slot;
        col_n   = col;
        if (line_start) begin
            state_n = S_SCAN;
            slot_n  = SW'(NUM_SPRITES - 1);
            col_n   = '0;
        end else begin
            case (state)
                S_IDLE: state_n = S_IDLE;
                S_SCAN: begin
                    if (hit) begin
                        state_n = S_FETCH;
                        col_n   = '0;
                    end else if (slot == '0) begin
                        state_n = S_DONE;
                    end else begin
                        slot_n = slot - 1'b1;
                    end
                end
                S_FETCH: begin
                    if (col == cur.dim - 7'd1) state_n = S_DRAIN;
                    else col_n = col + 7'd1;
                end
                S_DRAIN: begin
                    state_n = slot == '0 ? S_DONE : S_SCAN;
                    slot_n  = slot == '0 ? slot : slot - 1'b1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            slot  <= '0;
            col   <= '0;
            col_d <= '0;
            pend  <= 1'b0;
            line  <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) attr[i] <= '0;
        end else begin
            state <= state_n;
            slot  <= slot_n;
            col   <= col_n;
            col_d <= col;
            // a restarting line drops the write for the read issued this cycle
            pend  <= state == S_FETCH && !line_start;
            if (line_start) begin
                line <= next_line;
                for (int i = 0; i < NUM_SPRITES; i++) attr[i] <= sprite_attr[32*i +: 32];
            end
        end
    end

    assign wcol     = 11'(cur.x) + 11'(col_d);
    assign rom_sel  = state == S_FETCH ? cur.id : '0;
    assign rom_addr = state == S_FETCH ? ADDR_W'(17'(row) * 17'(cur.dim) + 17'(col)) : '0;
    assign lb_we    = pend && rom_data != '0 && wcol < 11'(HACTIVE);
    assign lb_addr  = lb_we ? wcol[9:0] : '0;
    assign lb_data  = lb_we ? rom_data : '0;
    assign busy     = state != S_IDLE;
    assign done     = state == S_DONE;
    assign overrun  = line_start && busy;

endmodule
